// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch-stage program counter with prioritised redirects.
//
// Computes the next fetch address every cycle from one of three places:
// a live redirect, a redirect buffered while fetch was stalled, or the
// sequential increment. The PC is registered, so no input reaches an
// output combinationally.
//
// Parameters
//   WIDTH     address width in bits
//   NUM_SRC   number of redirect sources; index NUM_SRC-1 has top priority
//   INC       sequential increment added to pc
//   RESET_VEC pc value loaded by reset
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   stall           hold pc this cycle
//   redirect_valid  per-source redirect request
//   redirect_target packed targets, source i at [i*WIDTH +: WIDTH]
//   pc              current fetch address
//   pc_valid        pc holds a fetchable address
//   redirected      pc was loaded from a redirect on the last edge
//   pending         a redirect is buffered awaiting stall release
module next_pc_unit #(
    parameter int                 WIDTH     = 32,
    parameter int                 NUM_SRC   = 3,
    parameter int                 INC       = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [NUM_SRC-1:0]       redirect_valid,
    input  logic [NUM_SRC*WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0]         pc,
    output logic                     pc_valid,
    output logic                     redirected,
    output logic                     pending
);

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] tgt;
    } redir_t;

    redir_t live;   // winning redirect this cycle
    redir_t pend;   // one-deep buffer filled while stalled

    // Scan upward so the highest set index overwrites lower ones.
    always_comb begin
        live = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (redirect_valid[i]) begin
                live.vld = 1'b1;
                live.tgt = redirect_target[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_VEC;
            pc_valid   <= 1'b0;
            redirected <= 1'b0;
            pend       <= '0;
        end else begin
            pc_valid <= 1'b1;
            if (stall) begin
                // Hold pc; latest live redirect replaces any buffered one.
                redirected <= 1'b0;
                if (live.vld)
                    pend <= live;
            end else if (live.vld) begin
                // Live redirect supersedes a stale buffered entry.
                pc         <= live.tgt;
                redirected <= 1'b1;
                pend.vld   <= 1'b0;
            end else if (pend.vld) begin
                pc         <= pend.tgt;
                redirected <= 1'b1;
                pend.vld   <= 1'b0;
            end else begin
                // Carry out of the top bit is dropped; wrap to 0 is legal.
                pc         <= pc + WIDTH'(INC);
                redirected <= 1'b0;
            end
        end
    end

    assign pending = pend.vld;

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;
    localparam int          W   = 32;
    localparam int          NS  = 3;
    localparam int          INC = 4;
    localparam logic [31:0] RV  = 32'h100;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic [NS-1:0]   rv = '0;
    logic [NS*W-1:0] rt = '0;
    logic [W-1:0]    pc;
    logic            pc_valid, redirected, pending;

    int n_chk = 0;
    int n_err = 0;

    next_pc_unit #(.WIDTH(W), .NUM_SRC(NS), .INC(INC), .RESET_VEC(RV)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(rv), .redirect_target(rt),
        .pc(pc), .pc_valid(pc_valid), .redirected(redirected), .pending(pending)
    );

    always #5 clk = ~clk;

    // Behavioural reference: state of the fetch PC as the rules describe it.
    logic [W-1:0] m_pc;
    logic         m_valid, m_redir, m_pend, m_ok = 1'b0;
    logic [W-1:0] m_ptgt;

    always @(posedge clk) begin : model
        logic         hit;
        logic [W-1:0] tgt;
        hit = 1'b0;
        tgt = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (!hit && rv[i]) begin
                hit = 1'b1;
                tgt = rt[i*W +: W];
            end
        if (!rst_n) begin
            m_pc = RV; m_valid = 0; m_redir = 0; m_pend = 0; m_ptgt = '0; m_ok = 1;
        end else begin
            m_valid = 1;
            if (stall) begin
                m_redir = 0;
                if (hit) begin m_pend = 1; m_ptgt = tgt; end
            end else if (hit) begin
                m_pc = tgt; m_redir = 1; m_pend = 0;
            end else if (m_pend) begin
                m_pc = m_ptgt; m_redir = 1; m_pend = 0;
            end else begin
                m_pc = W'((64'(m_pc) + INC) % (64'd1 << W));
                m_redir = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("pc", 64'(pc), 64'(m_pc));
            chk("pc_valid", 64'(pc_valid), 64'(m_valid));
            chk("redirected", 64'(redirected), 64'(m_redir));
            chk("pending", 64'(pending), 64'(m_pend));
        end
    end

    function automatic logic [NS*W-1:0] tg(input logic [W-1:0] a2, a1, a0);
        return {a2, a1, a0};
    endfunction

    // Apply inputs, take one edge, let outputs settle.
    task automatic cyc(input logic s, input logic [NS-1:0] v, input logic [NS*W-1:0] t);
        stall = s; rv = v; rt = t;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset and increment
        rst_n = 0;
        cyc(0, 3'b000, '0);
        cyc(0, 3'b000, '0);
        chk("rst_pc", 64'(pc), 64'h100);
        chk("rst_valid", 64'(pc_valid), 64'h0);
        chk("rst_pending", 64'(pending), 64'h0);
        rst_n = 1;
        cyc(0, 3'b000, '0);
        chk("inc1", 64'(pc), 64'h104);
        chk("valid_up", 64'(pc_valid), 64'h1);
        cyc(0, 3'b000, '0);
        chk("inc2", 64'(pc), 64'h108);
        cyc(0, 3'b000, '0);
        chk("inc3", 64'(pc), 64'h10C);
        // Priority
        cyc(0, 3'b011, tg(32'h0, 32'h300, 32'h200));
        chk("prio_011", 64'(pc), 64'h300);
        chk("prio_redir", 64'(redirected), 64'h1);
        cyc(0, 3'b111, tg(32'h400, 32'h300, 32'h200));
        chk("prio_111", 64'(pc), 64'h400);
        cyc(0, 3'b000, '0);
        chk("after_redir", 64'(pc), 64'h404);
        chk("redir_drop", 64'(redirected), 64'h0);
        // Stall buffering, latest wins
        cyc(1, 3'b001, tg(32'h0, 32'h0, 32'h500));
        chk("stall_hold", 64'(pc), 64'h404);
        chk("stall_pend", 64'(pending), 64'h1);
        chk("stall_noredir", 64'(redirected), 64'h0);
        cyc(1, 3'b010, tg(32'h0, 32'h600, 32'h0));
        cyc(1, 3'b000, '0);
        chk("stall_hold3", 64'(pc), 64'h404);
        cyc(0, 3'b000, '0);
        chk("pend_apply", 64'(pc), 64'h600);
        chk("pend_redir", 64'(redirected), 64'h1);
        chk("pend_clear", 64'(pending), 64'h0);
        cyc(0, 3'b000, '0);
        chk("pend_inc", 64'(pc), 64'h604);
        // Live beats pending
        cyc(1, 3'b001, tg(32'h0, 32'h0, 32'h700));
        cyc(0, 3'b100, tg(32'h800, 32'h0, 32'h0));
        chk("live_wins", 64'(pc), 64'h800);
        chk("live_clr", 64'(pending), 64'h0);
        cyc(0, 3'b000, '0);
        chk("stale_gone", 64'(pc), 64'h804);
        // Wrap
        cyc(0, 3'b001, tg(32'h0, 32'h0, 32'hFFFF_FFFC));
        cyc(0, 3'b000, '0);
        chk("wrap", 64'(pc), 64'h0);
        chk("wrap_noredir", 64'(redirected), 64'h0);
        // Reset mid-stall discards buffer
        cyc(1, 3'b001, tg(32'h0, 32'h0, 32'h900));
        chk("pre_rst_pend", 64'(pending), 64'h1);
        rst_n = 0;
        cyc(1, 3'b000, '0);
        chk("midrst_pc", 64'(pc), 64'h100);
        chk("midrst_pend", 64'(pending), 64'h0);
        rst_n = 1;
        cyc(1, 3'b000, '0);
        chk("rel_stall_hold", 64'(pc), 64'h100);
        chk("rel_stall_valid", 64'(pc_valid), 64'h1);
        cyc(0, 3'b000, '0);
        chk("rel_inc", 64'(pc), 64'h104);
        chk("rel_noredir", 64'(redirected), 64'h0);
        cyc(0, 3'b000, '0);
        chk("no_900", 64'(pc), 64'h108);
        // Randomised run, checked every cycle by the compare process
        for (int k = 0; k < 3000; k++) begin
            logic [NS-1:0] v;
            rst_n = ($urandom_range(0, 99) != 0);
            v = '0;
            for (int i = 0; i < NS; i++)
                v[i] = ($urandom_range(0, 5) == 0);
            cyc($urandom_range(0, 2) == 0, v,
                {$urandom, $urandom, ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom});
        end
        rst_n = 1;
        cyc(0, 3'b000, '0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
